// File: rtl/ext_bus_arbiter.sv
// Shared external bus sequencer: two requesters (m0 = CPU, m1 = DMA) time-share the address/data pads.
// Define EXT_BUS_ARB_RR_EN for round-robin arbitration; default is fixed m1-over-m0 priority.
module ext_bus_arbiter #(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter logic [15:0] IDLE_ADDR     = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [15:0] m0_a,
   input  logic [7:0]  m0_wdata,
   output logic        m0_ack,
   output logic [7:0]  m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [15:0] m1_a,
   input  logic [7:0]  m1_wdata,
   output logic        m1_ack,
   output logic [7:0]  m1_rdata,
   output logic [15:0] bus_a,
   output logic [7:0]  bus_dout,
   output logic        bus_doe,
   output logic        bus_wr,
   input  logic [7:0]  bus_din,
   output logic        busy
);

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ADDR, STROBE, DONE} state_t;

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic        grant, grant_next;
   logic        lat_we, lat_we_next;
   logic        win;
   logic [15:0] bus_a_next;
   logic [7:0]  bus_dout_next;
   logic        bus_doe_next, bus_wr_next, busy_next;
   logic        m0_ack_next, m1_ack_next;
   logic [7:0]  m0_rdata_next, m1_rdata_next;

`ifdef EXT_BUS_ARB_RR_EN
   logic last;

   always_comb begin
      if (m0_req && m1_req) win = ~last;
      else                  win = m1_req;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                  last <= 1'b1;
      else if (state == IDLE && (m0_req || m1_req)) last <= win;
   end
`else
   always_comb win = m1_req;
`endif

   // Outputs are computed for the state being entered, so they change on the same edge as the state.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      grant_next    = grant;
      lat_we_next   = lat_we;
      bus_a_next    = bus_a;
      bus_dout_next = bus_dout;
      bus_doe_next  = bus_doe;
      bus_wr_next   = bus_wr;
      busy_next     = busy;
      m0_ack_next   = 1'b0;
      m1_ack_next   = 1'b0;
      m0_rdata_next = m0_rdata;
      m1_rdata_next = m1_rdata;
      case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               state_next   = ADDR;
               grant_next   = win;
               lat_we_next  = win ? m1_we : m0_we;
               bus_a_next   = win ? m1_a : m0_a;
               bus_doe_next = lat_we_next;
               if (lat_we_next) bus_dout_next = win ? m1_wdata : m0_wdata;
               bus_wr_next  = 1'b0;
               busy_next    = 1'b1;
            end
         end
         ADDR: begin
            state_next  = STROBE;
            cnt_next    = CNT_LOAD;
            bus_wr_next = lat_we;
         end
         STROBE: begin
            if (cnt == 4'd0) begin
               state_next   = DONE;
               bus_wr_next  = 1'b0;
               bus_doe_next = 1'b0;
               if (grant) m1_ack_next = 1'b1;
               else       m0_ack_next = 1'b1;
               if (!lat_we) begin
                  if (grant) m1_rdata_next = bus_din;
                  else       m0_rdata_next = bus_din;
               end
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         DONE: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         grant    <= 1'b0;
         lat_we   <= 1'b0;
         bus_a    <= IDLE_ADDR;
         bus_dout <= 8'd0;
         bus_doe  <= 1'b0;
         bus_wr   <= 1'b0;
         busy     <= 1'b0;
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_rdata <= 8'd0;
         m1_rdata <= 8'd0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         grant    <= grant_next;
         lat_we   <= lat_we_next;
         bus_a    <= bus_a_next;
         bus_dout <= bus_dout_next;
         bus_doe  <= bus_doe_next;
         bus_wr   <= bus_wr_next;
         busy     <= busy_next;
         m0_ack   <= m0_ack_next;
         m1_ack   <= m1_ack_next;
         m0_rdata <= m0_rdata_next;
         m1_rdata <= m1_rdata_next;
      end
   end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Self-checking bench for ext_bus_arbiter (default fixed-priority build, ACCESS_CYCLES = 2).
module tb_ext_bus_arbiter;

   localparam int ACC = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [15:0] m0_a = '0, m1_a = '0;
   logic [7:0]  m0_wdata = '0, m1_wdata = '0;
   logic        m0_ack, m1_ack;
   logic [7:0]  m0_rdata, m1_rdata;
   logic [15:0] bus_a;
   logic [7:0]  bus_dout;
   logic        bus_doe, bus_wr, busy;
   logic [7:0]  bus_din = '0;

   typedef struct packed {
      logic        id;
      logic        we;
      logic [15:0] a;
      logic [7:0]  wdata;
      logic [7:0]  din;
   } vec_t;

   typedef struct packed {
      logic        id;
      logic        we;
      logic [15:0] a;
      logic [7:0]  data;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[6];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;

   ext_bus_arbiter #(.ACCESS_CYCLES(ACC), .IDLE_ADDR(16'hFFFF)) dut (
      .clk(clk), .rstn(rstn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_a(m0_a), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_a(m1_a), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .bus_a(bus_a), .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_wr(bus_wr),
      .bus_din(bus_din), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic drive_req(input logic id, input logic we, input logic [15:0] a, input logic [7:0] wd);
      if (id) begin m1_req = 1'b1; m1_we = we; m1_a = a; m1_wdata = wd; end
      else    begin m0_req = 1'b1; m0_we = we; m0_a = a; m0_wdata = wd; end
   endtask

   task automatic drop_req(input logic id);
      if (id) m1_req = 1'b0;
      else    m0_req = 1'b0;
   endtask

   task automatic push_exp(input logic id, input logic we, input logic [15:0] a, input logic [7:0] data);
      exp_t e;
      e.id = id; e.we = we; e.a = a; e.data = data;
      sb.push_back(e);
   endtask

   // Single isolated access: checks latency and how many cycles the strobe/enable were asserted.
   task automatic applyStimulus(input vec_t v);
      int   n, wr_n, doe_n;
      logic got;
      @(posedge clk); #1;
      bus_din = v.din;
      drive_req(v.id, v.we, v.a, v.wdata);
      push_exp(v.id, v.we, v.a, v.we ? v.wdata : v.din);
      n = 0; wr_n = 0; doe_n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk); n++;
         @(negedge clk);
         got = v.id ? m1_ack : m0_ack;
         if (!got) begin wr_n += int'(bus_wr); doe_n += int'(bus_doe); end
      end
      checkOutput("latency", n, ACC + 2);
      checkOutput("wr_cycles", wr_n, v.we ? ACC : 0);
      checkOutput("doe_cycles", doe_n, v.we ? ACC + 1 : 0);
      drop_req(v.id);
   endtask

   // Requester that keeps req high across acks, stepping address/data after each ack.
   task automatic run_master(input logic id, input logic we, input int count,
                             input logic [15:0] base, input logic [7:0] dbase, input bit chk_gap);
      int   prev;
      logic got;
      prev = 0;
      drive_req(id, we, base, dbase);
      for (int i = 0; i < count; i++) begin
         got = 1'b0;
         for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = id ? m1_ack : m0_ack;
         end
         if (!got) checkOutput("master_timeout", 0, 1);
         if (chk_gap && i > 0) checkOutput("ack_gap", cyc - prev, ACC + 3);
         prev = cyc;
         if (i + 1 < count) drive_req(id, we, base + 16'(i + 1), dbase + 8'(i + 1));
         else               drop_req(id);
      end
   endtask

   // Scoreboard: every ack is matched against the oldest expected access.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (m0_ack || m1_ack) begin
            checkOutput("ack_exclusive", {31'd0, m0_ack & m1_ack}, 0);
            if (sb.size() == 0) checkOutput("unexpected_ack", 1, 0);
            else begin
               e = sb.pop_front();
               checkOutput("grant_id", {31'd0, m1_ack}, {31'd0, e.id});
               checkOutput("bus_addr", {16'd0, bus_a}, {16'd0, e.a});
               if (e.we) checkOutput("write_data", {24'd0, bus_dout}, {24'd0, e.data});
               else      checkOutput("read_data", {24'd0, e.id ? m1_rdata : m0_rdata}, {24'd0, e.data});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   acks;
      logic seen;
      vecs[0] = '{id: 1'b0, we: 1'b0, a: 16'h4000, wdata: 8'h00, din: 8'h5A};
      vecs[1] = '{id: 1'b1, we: 1'b1, a: 16'hA010, wdata: 8'hC3, din: 8'h00};
      vecs[2] = '{id: 1'b1, we: 1'b0, a: 16'h0123, wdata: 8'hEE, din: 8'h3C};
      vecs[3] = '{id: 1'b0, we: 1'b1, a: 16'hFFFE, wdata: 8'h81, din: 8'h11};
      vecs[4] = '{id: 1'b0, we: 1'b0, a: 16'h0000, wdata: 8'h00, din: 8'hFF};
      vecs[5] = '{id: 1'b1, we: 1'b1, a: 16'h7F00, wdata: 8'h5E, din: 8'h22};

      rstn = 1'b0;
      #12;
      checkOutput("rst_bus_a", {16'd0, bus_a}, 32'hFFFF);
      checkOutput("rst_bus_dout", {24'd0, bus_dout}, 0);
      checkOutput("rst_bus_doe", {31'd0, bus_doe}, 0);
      checkOutput("rst_bus_wr", {31'd0, bus_wr}, 0);
      checkOutput("rst_busy", {31'd0, busy}, 0);
      checkOutput("rst_acks", {30'd0, m1_ack, m0_ack}, 0);
      checkOutput("rst_rdata", {16'd0, m1_rdata, m0_rdata}, 0);
      @(negedge clk); rstn = 1'b1;

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      // Contention: fixed priority drains all m1 requests before m0 gets the bus.
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b1, 16'hB000 + 16'(i), 8'h10 + 8'(i));
      for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b1, 16'hC000 + 16'(i), 8'h20 + 8'(i));
      fork
         run_master(1'b1, 1'b1, 3, 16'hB000, 8'h10, 1'b0);
         run_master(1'b0, 1'b1, 3, 16'hC000, 8'h20, 1'b0);
      join

      // Back-to-back reads from m0 with stepping address.
      @(posedge clk); #1;
      bus_din = 8'h77;
      for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b0, 16'(i), 8'h77);
      run_master(1'b0, 1'b0, 3, 16'h0000, 8'h00, 1'b1);

      // Early drop: req released during STROBE still yields exactly one ack.
      @(posedge clk); #1;
      bus_din = 8'h99;
      drive_req(1'b0, 1'b0, 16'h2222, 8'h00);
      push_exp(1'b0, 1'b0, 16'h2222, 8'h99);
      @(posedge clk); @(posedge clk); #1;
      drop_req(1'b0);
      acks = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         acks += int'(m0_ack);
      end
      checkOutput("early_drop_acks", acks, 1);
      checkOutput("early_drop_idle", {31'd0, busy}, 0);

      // Reset in the middle of a write strobe aborts it without an ack.
      @(posedge clk); #1;
      drive_req(1'b1, 1'b1, 16'h5555, 8'hAA);
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = bus_wr;
      end
      checkOutput("strobe_seen", {31'd0, seen}, 1);
      rstn = 1'b0;
      drop_req(1'b1);
      #1;
      checkOutput("abort_bus_wr", {31'd0, bus_wr}, 0);
      checkOutput("abort_bus_doe", {31'd0, bus_doe}, 0);
      checkOutput("abort_bus_a", {16'd0, bus_a}, 32'hFFFF);
      checkOutput("abort_busy", {31'd0, busy}, 0);
      @(negedge clk); @(negedge clk);
      checkOutput("abort_no_ack", {30'd0, m1_ack, m0_ack}, 0);
      rstn = 1'b1;
      applyStimulus('{id: 1'b1, we: 1'b0, a: 16'h1234, wdata: 8'h00, din: 8'h6D});

      @(posedge clk); @(negedge clk);
      checkOutput("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
